pmp_check_seq: RTL and testbench

Sequential PMP permission checker for the load/store path. For each access request it walks the PMP entries through the PMP CSR read port, one entry at a time, and returns grant or fault. The CSR read port is shared with the core's CSR-instruction path, and the core always has priority. The block sits between the load/store unit and `pmp_unit`.

---
 rtl/global_pkg.sv | 7 +
 rtl/pmp_check_seq_match.sv | 30 +++
 rtl/pmp_check_seq.sv | 102 ++++++++++
 tb/tb_pmp_check_seq.sv | 212 +++++++++++++++++++++
 4 files changed

// File: rtl/global_pkg.sv
// global_pkg: access types, PMP address-matching modes and CSR numbers shared by the PMP checker.
package global_pkg;
    typedef enum logic [1:0] {ACC_R, ACC_W, ACC_X} access_t;
    typedef enum logic [1:0] {A_OFF, A_TOR, A_NA4, A_NAPOT} pmp_a_t;
    localparam logic [11:0] CSR_PMPCFG0  = 12'h3A0;
    localparam logic [11:0] CSR_PMPADDR0 = 12'h3B0;
endpackage

// File: rtl/pmp_check_seq_match.sv
// pmp_match: single-entry region match and permission decision.
// NA4/NAPOT matching exists only when PMP_NAPOT_EN is defined; otherwise only TOR can match.
module pmp_match
    import global_pkg::*;
(
    input  logic [31:0] wa,
    input  logic [31:0] prev,
    input  logic [31:0] a,
    input  logic [7:0]  e,
    input  access_t     acc,
    input  logic        priv_m,
    output logic        hit,
    output logic        fault
);
    pmp_a_t mode;
    logic   perm;
    assign mode = pmp_a_t'(e[4:3]);
    assign perm = acc == ACC_R ? e[0] : acc == ACC_W ? e[1] : e[2];
`ifdef PMP_NAPOT_EN
    logic [31:0] mask;
    assign mask = ~(a ^ (a + 32'd1));
    assign hit  = mode == A_TOR   ? (prev <= wa && wa < a) :
                  mode == A_NA4   ? wa == a :
                  mode == A_NAPOT ? ((wa ^ a) & mask) == 32'd0 : 1'b0;
`else
    assign hit = mode == A_TOR && prev <= wa && wa < a;
`endif
    // M-mode bypasses unlocked entries
    assign fault = !(priv_m && !e[7]) && !perm;
endmodule

// File: rtl/pmp_check_seq.sv
// pmp_check_seq: walks PMP entries over the shared CSR read port and grants or faults one access.
// Build option PMP_NAPOT_EN enables NA4/NAPOT region matching in pmp_match.
module pmp_check_seq
    import global_pkg::*;
#(
    parameter int N_ENTRIES = 16
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [31:0] req_addr,
    input  access_t     req_type,
    input  logic        req_priv_m,
    output logic        resp_valid,
    input  logic        resp_ready,
    output logic        resp_fault,
    input  logic        csr_busy,
    output logic        cfg_rd,
    output logic [11:0] cfg_addr,
    input  logic [31:0] cfg_data
);
    typedef enum logic [2:0] {IDLE, RD_CFG, RD_ADDR, EVAL, DONE} state_t;
    state_t      state, state_n;
    logic [29:0] wa;
    access_t     acc;
    logic        priv_m, cfg_pend, hit, fault, last, unused_ok;
    logic [3:0]  idx;
    logic [31:0] prev, cfg_word;
    logic [7:0]  e;
    assign e         = cfg_word[{idx[1:0], 3'b000} +: 8];
    assign last      = idx == 4'(N_ENTRIES - 1);
    assign unused_ok = ^req_addr[1:0];

    pmp_match u_match (
        .wa({2'b00, wa}), .prev(prev), .a(cfg_data), .e(e),
        .acc(acc), .priv_m(priv_m), .hit(hit), .fault(fault)
    );

    always_comb begin
        state_n    = state;
        req_ready  = 1'b0;
        resp_valid = 1'b0;
        cfg_rd     = 1'b0;
        cfg_addr   = 12'h000;
        case (state)
            IDLE: begin
                req_ready = !rst;
                if (req_valid && !rst) state_n = RD_CFG;
            end
            RD_CFG: begin
                cfg_rd   = !csr_busy;
                cfg_addr = CSR_PMPCFG0 + {10'd0, idx[3:2]};
                if (!csr_busy) state_n = RD_ADDR;
            end
            RD_ADDR: begin
                cfg_rd   = !csr_busy;
                cfg_addr = CSR_PMPADDR0 + {8'd0, idx};
                if (!csr_busy) state_n = EVAL;
            end
            EVAL: state_n = (hit || last) ? DONE : idx[1:0] == 2'd3 ? RD_CFG : RD_ADDR;
            DONE: begin
                resp_valid = 1'b1;
                if (resp_ready) state_n = IDLE;
            end
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            resp_fault <= 1'b0;
            cfg_pend   <= 1'b0;
            idx        <= 4'd0;
            prev       <= 32'd0;
            wa         <= 30'd0;
            acc        <= ACC_R;
            priv_m     <= 1'b0;
            cfg_word   <= 32'd0;
        end else begin
            state    <= state_n;
            // read data arrives exactly one cycle after issue, so capture it then even if RD_ADDR stalls
            cfg_pend <= state == RD_CFG && !csr_busy;
            if (state == IDLE && req_valid) begin
                wa     <= req_addr[31:2];
                acc    <= req_type;
                priv_m <= req_priv_m;
                idx    <= 4'd0;
                prev   <= 32'd0;
            end
            if (state == RD_ADDR && cfg_pend) cfg_word <= cfg_data;
            if (state == EVAL) begin
                resp_fault <= hit ? fault : !priv_m;
                if (!hit) begin
                    prev <= cfg_data;
                    idx  <= idx + 4'd1;
                end
            end
        end
    end
endmodule

// File: tb/tb_pmp_check_seq.sv
// tb_pmp_check_seq: randomized and directed checks of pmp_check_seq against a behavioural PMP model.
module tb_pmp_check_seq;
    import global_pkg::*;
    localparam int N = 16;
    logic        clk = 0, rst = 1;
    logic        req_valid = 0, req_priv_m = 0, resp_ready = 0, csr_busy = 0;
    logic        req_ready, resp_valid, resp_fault, cfg_rd;
    logic [31:0] req_addr = 0, cfg_data;
    access_t     req_type = ACC_R;
    logic [11:0] cfg_addr;
    logic [7:0]  pcfg [N];
    logic [31:0] paddr [N];
    logic [11:0] issued [$];
    int          rd_busy = 0, n_chk = 0, n_pass = 0;

    pmp_check_seq #(.N_ENTRIES(N)) dut (
        .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready),
        .req_addr(req_addr), .req_type(req_type), .req_priv_m(req_priv_m),
        .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_fault(resp_fault),
        .csr_busy(csr_busy), .cfg_rd(cfg_rd), .cfg_addr(cfg_addr), .cfg_data(cfg_data)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] csr_read(input logic [11:0] ad);
        int q = int'(ad) - 'h3A0;
        int j = int'(ad) - 'h3B0;
        if (q >= 0 && q < N / 4) return {pcfg[4*q+3], pcfg[4*q+2], pcfg[4*q+1], pcfg[4*q]};
        if (j >= 0 && j < N) return paddr[j];
        return $urandom;
    endfunction

    // pmp_unit stand-in: data one cycle after an issued read, junk otherwise
    always @(posedge clk) begin
        if (cfg_rd && csr_busy) rd_busy <= rd_busy + 1;
        if (cfg_rd && !csr_busy) issued.push_back(cfg_addr);
        cfg_data <= (cfg_rd && !csr_busy) ? csr_read(cfg_addr) : $urandom;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    endtask

    // k = first matching entry (N if none), f = expected fault
    function automatic void model(input logic [31:0] addr, input int t, input bit pm, output int k, output bit f);
        longint wa, lo, a, p;
        bit m;
        wa = longint'(addr >> 2);
        lo = 0;
        k = N;
        f = !pm;
        for (int i = 0; i < N; i++) begin
            a = longint'(paddr[i]);
            m = 0;
            case (pcfg[i][4:3])
                2'd1: m = lo <= wa && wa < a;
`ifdef PMP_NAPOT_EN
                2'd2: m = wa == a;
                2'd3: begin
                    p = 1;
                    while (p < 64'h1_0000_0000 && (a / p) % 2 == 1) p = p * 2;
                    m = wa >= a - a % (2 * p) && wa < a - a % (2 * p) + 2 * p;
                end
`endif
                default: m = 0;
            endcase
            if (m) begin
                k = i;
                f = (pm && !pcfg[i][7]) ? 1'b0 : !pcfg[i][t];
                return;
            end
            lo = a;
        end
    endfunction

    // cycle of resp_valid: each read waits out busy cycles, then one cycle to issue; EVAL one cycle
    function automatic int exp_lat(input int k_last, input int bs, input int bl);
        int t = 1;
        for (int i = 0; i <= k_last; i++) begin
            if (i % 4 == 0) begin
                while (t >= bs && t < bs + bl) t++;
                t++;
            end
            while (t >= bs && t < bs + bl) t++;
            t += 2;
        end
        return t;
    endfunction

    task automatic clear_cfg();
        for (int i = 0; i < N; i++) begin
            pcfg[i] = 8'h00;
            paddr[i] = 32'd0;
        end
    endtask

    task automatic rand_cfg();
        int md, t;
        logic [31:0] a;
        for (int i = 0; i < N; i++) begin
            md = $urandom_range(0, 3);
            t = $urandom_range(0, 8);
            a = 32'($urandom_range(0, 'h7FF));
            if (md == 3) a = ((a >> (t + 1)) << (t + 1)) | ((32'd1 << t) - 32'd1);
            paddr[i] = $urandom_range(0, 15) == 0 ? $urandom : a;
            pcfg[i] = {1'($urandom_range(0, 1)), 2'b00, 2'(md), 3'($urandom_range(0, 7))};
        end
    endtask

    task automatic run_req(input string tag, input logic [31:0] addr, input access_t t, input bit pm,
                           input int bs, input int bl, input int hold);
        int k, lat, cyc, k_last, busy0;
        bit f;
        logic [11:0] exp_q [$];
        model(addr, int'(t), pm, k, f);
        k_last = k < N ? k : N - 1;
        lat = exp_lat(k_last, bs, bl);
        for (int i = 0; i <= k_last; i++) begin
            if (i % 4 == 0) exp_q.push_back(12'h3A0 + 12'(i / 4));
            exp_q.push_back(12'h3B0 + 12'(i));
        end
        @(negedge clk);
        issued.delete();
        busy0 = rd_busy;
        check({tag, "_rdy"}, req_ready, 1);
        req_valid = 1; req_addr = addr; req_type = t; req_priv_m = pm;
        cyc = 0;
        do begin
            @(negedge clk);
            cyc++;
            req_valid = 1'($urandom_range(0, 1));
            req_addr = $urandom;
            csr_busy = cyc >= bs && cyc < bs + bl;
            #1;
            if (csr_busy) check({tag, "_busy_rd"}, cfg_rd, 0);
        end while (!resp_valid && cyc < 200);
        req_valid = 0;
        csr_busy = 0;
        check({tag, "_lat"}, cyc, lat);
        check({tag, "_fault"}, resp_fault, f);
        for (int h = 0; h < hold; h++) begin
            @(negedge clk);
            #1 check({tag, "_hold"}, {resp_valid, resp_fault}, {1'b1, f});
        end
        resp_ready = 1;
        @(negedge clk);
        resp_ready = 0;
        #1;
        check({tag, "_b2b"}, {req_ready, resp_valid}, 2'b10);
        check({tag, "_nrd"}, issued.size(), exp_q.size());
        for (int i = 0; i < exp_q.size() && i < issued.size(); i++) check({tag, "_raddr"}, issued[i], exp_q[i]);
        check({tag, "_rd_while_busy"}, rd_busy - busy0, 0);
    endtask

    task automatic reset_mid_walk();
        clear_cfg();
        @(negedge clk);
        req_valid = 1; req_addr = 32'h1000; req_type = ACC_R; req_priv_m = 0;
        for (int c = 1; c <= 10; c++) begin
            @(negedge clk);
            req_valid = 0;
        end
        rst = 1;
        #1 check("mid_rst_rdy", req_ready, 0);
        @(negedge clk);
        rst = 0;
        #1;
        check("mid_rst_outs", {req_ready, resp_valid, cfg_rd, resp_fault}, 4'b1000);
        check("mid_rst_addr", cfg_addr, 0);
    endtask

    initial begin
        clear_cfg();
        repeat (3) @(negedge clk);
        #1;
        check("rst_rdy", req_ready, 0);
        check("rst_outs", {resp_valid, cfg_rd, cfg_addr}, 0);
        rst = 0;
        #1 check("post_rst_rdy", req_ready, 1);
        check("post_rst_fault", resp_fault, 0);
        // NAPOT base 0, 4 KiB, R only
        pcfg[0] = 8'h19; paddr[0] = 32'h1FF;
        run_req("napot_r", 32'h800, ACC_R, 0, 99, 0, 0);
        run_req("napot_w", 32'h800, ACC_W, 0, 99, 0, 1);
        run_req("napot_miss", 32'h1000, ACC_R, 0, 99, 0, 0);
        run_req("napot_busy", 32'h800, ACC_R, 0, 2, 5, 0);
        // TOR entry 1 over [0x100,0x400) words, X only
        clear_cfg();
        paddr[0] = 32'h100; pcfg[1] = 8'h0C; paddr[1] = 32'h400;
        run_req("tor_x", 32'h400, ACC_X, 0, 99, 0, 0);
        run_req("tor_miss_u", 32'h1000, ACC_X, 0, 99, 0, 0);
        run_req("tor_miss_m", 32'h1000, ACC_X, 1, 99, 0, 0);
        // NA4 entry 2 at 0x2000, R only, locked then unlocked
        clear_cfg();
        pcfg[2] = 8'h91; paddr[2] = 32'h800;
        run_req("na4_lock", 32'h2000, ACC_W, 1, 99, 0, 0);
        pcfg[2] = 8'h11;
        run_req("na4_unlock", 32'h2000, ACC_W, 1, 99, 0, 0);
        reset_mid_walk();
        run_req("after_rst", 32'h1000, ACC_R, 0, 99, 0, 0);
        for (int n = 0; n < 48; n++) begin
            if (n % 8 == 0) rand_cfg();
            run_req("rnd", $urandom_range(0, 7) == 0 ? $urandom : 32'($urandom_range(0, 'h2000)),
                    access_t'($urandom_range(0, 2)), 1'($urandom_range(0, 1)),
                    $urandom_range(1, 20), $urandom_range(0, 4), $urandom_range(0, 2));
        end
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
